jump_target_unit: RTL and testbench

Computes control-transfer targets (J, JAL, JR, conditional branch) for the MIPS fetch path and delivers them to the PC stage as a registered redirect with a valid/ready handshake. It sits between decode and the PC register and replaces the fixed 32-bit jump concatenation with a width-parametrised unit that also handles branches, link addresses, back-pressure, flush and an optional return-address stack.

---
 rtl/jump_target_unit.sv | 133 +++++++++++++
 tb/tb_jump_target_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jump_target_unit.sv
// jump_target_unit: computes J/JAL/JR/BRANCH targets and link values and
// holds them in a single-entry registered redirect slot for the PC stage.
// Latency: request accepted at edge N shows as redir_valid/redir_target right after edge N.
// Backpressure: req_ready drops while a redirect is held with redir_ready low, or during flush.
// Ports: clk/rst_n (async active-low); req_* from decode (valid/ready);
//        flush drops the pending redirect and any same-cycle request;
//        redir_* to the PC stage (valid/ready), redir_link/redir_link_we carry the $ra write;
//        ras_hit reports a return-address-stack match on JR.
// Optional feature: define JTU_RAS_EN to build the RAS_DEPTH-entry return-address
// stack; without it there is no stack storage and ras_hit is always 0.
module jump_target_unit #(
    parameter int ADDR_W    = 32,
    parameter int IDX_W     = 26,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [ADDR_W-1:0] req_pc,
    input  logic [IDX_W-1:0]  req_index,
    input  logic [ADDR_W-1:0] req_reg,
    input  logic [15:0]       req_offset,
    input  logic              req_taken,
    input  logic              flush,
    output logic              redir_valid,
    input  logic              redir_ready,
    output logic [ADDR_W-1:0] redir_target,
    output logic [ADDR_W-1:0] redir_link,
    output logic              redir_link_we,
    output logic              ras_hit
);

    typedef enum logic [1:0] {K_J = 2'b00, K_JAL = 2'b01, K_JR = 2'b10, K_BR = 2'b11} kind_e;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    // Low IDX_W+2 bits come from the instruction index; the rest from req_pc.
    // When ADDR_W == IDX_W+2 the mask is all ones and no PC bits survive.
    localparam logic [ADDR_W-1:0] IDX_MASK = {ADDR_W{1'b1}} >> (ADDR_W - IDX_W - 2);

    generate
        if (ADDR_W < IDX_W + 2 || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_cfg_check
            $error("jump_target_unit: illegal ADDR_W/IDX_W/RAS_DEPTH combination");
        end
    endgenerate

    state_e            state_q;
    logic [ADDR_W-1:0] target_q, link_q;
    logic              link_we_q, ras_hit_q;

    logic [ADDR_W-1:0] target_d, link_d, jump_tgt, br_off;
    logic              accept, produce, hit_d;

    assign redir_valid   = (state_q == FULL);
    assign redir_target  = target_q;
    assign redir_link    = link_q;
    assign redir_link_we = link_we_q;

    assign req_ready = !flush && (!redir_valid || redir_ready);
    assign accept    = req_valid && req_ready;
    // A not-taken branch is consumed but leaves the redirect slot untouched.
    assign produce   = accept && !(req_kind == K_BR && !req_taken);

    assign jump_tgt = ADDR_W'({req_index, 2'b00}) | (req_pc & ~IDX_MASK);
    // Casting the signed word offset to ADDR_W sign-extends it.
    assign br_off   = ADDR_W'($signed({req_offset, 2'b00}));
    assign link_d   = req_pc + ADDR_W'(4);

    always_comb begin
        target_d = jump_tgt;
        case (req_kind)
            K_JR:    target_d = req_reg;
            K_BR:    target_d = req_pc + br_off;
            default: target_d = jump_tgt;
        endcase
    end

`ifdef JTU_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] ras_top;

    // ptr_q points at the next free slot; the newest entry sits just below it.
    assign ras_top = ras_q[ptr_q - PTR_W'(1)];
    assign hit_d   = (cnt_q != '0) && (ras_top == req_reg);
    assign ras_hit = ras_hit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else if (accept && req_kind == K_JAL) begin
            // Circular: once full, the push overwrites the oldest entry.
            ras_q[ptr_q] <= link_d;
            ptr_q        <= ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_q <= cnt_q + CNT_W'(1);
        end else if (accept && req_kind == K_JR && cnt_q != '0) begin
            ptr_q <= ptr_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end
`else
    assign hit_d   = 1'b0;
    assign ras_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            target_q  <= '0;
            link_q    <= '0;
            link_we_q <= 1'b0;
            ras_hit_q <= 1'b0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else if (produce) begin
            state_q   <= FULL;
            target_q  <= target_d;
            link_q    <= link_d;
            link_we_q <= (req_kind == K_JAL);
            ras_hit_q <= (req_kind == K_JR) && hit_d;
        end else if (redir_ready) begin
            state_q <= EMPTY;
        end
    end

endmodule

// File: tb/tb_jump_target_unit.sv
module tb_jump_target_unit;
    localparam int ADDR_W    = 32;
    localparam int IDX_W     = 26;
    localparam int RAS_DEPTH = 4;
`ifdef JTU_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0, req_ready;
    logic [1:0]        req_kind = 2'b00;
    logic [ADDR_W-1:0] req_pc = '0, req_reg = '0;
    logic [IDX_W-1:0]  req_index = '0;
    logic [15:0]       req_offset = '0;
    logic              req_taken = 1'b0, flush = 1'b0;
    logic              redir_valid, redir_ready = 1'b1;
    logic [ADDR_W-1:0] redir_target, redir_link;
    logic              redir_link_we, ras_hit;

    jump_target_unit #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_pc(req_pc), .req_index(req_index), .req_reg(req_reg),
        .req_offset(req_offset), .req_taken(req_taken), .flush(flush),
        .redir_valid(redir_valid), .redir_ready(redir_ready),
        .redir_target(redir_target), .redir_link(redir_link),
        .redir_link_we(redir_link_we), .ras_hit(ras_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: what the PC stage should currently see.
    bit          m_valid = 1'b0;
    logic [31:0] m_target = '0, m_link = '0;
    bit          m_we = 1'b0, m_hit = 1'b0;
    logic [31:0] ras_m [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Targets from the architectural rules using plain integer arithmetic.
    function automatic logic [31:0] model_target(input logic [1:0] k, input logic [31:0] pc,
                                                 input logic [25:0] idx, input logic [31:0] rg,
                                                 input logic [15:0] off);
        longint v;
        case (k)
            2'b10:   v = longint'(rg);
            2'b11:   v = longint'(pc) + 4 * longint'($signed(off));
            default: v = (longint'(pc) / 268435456) * 268435456 + longint'(idx) * 4;
        endcase
        return v[31:0];
    endfunction

    task automatic drive(input bit v, input logic [1:0] k, input logic [31:0] pc,
                         input logic [25:0] idx, input logic [31:0] rg, input logic [15:0] off,
                         input bit tk, input bit fl, input bit rr);
        req_valid = v; req_kind = k; req_pc = pc; req_index = idx; req_reg = rg;
        req_offset = off; req_taken = tk; flush = fl; redir_ready = rr;
    endtask

    // One clock: check req_ready and advance the model at the falling edge,
    // then check the registered outputs just after the rising edge.
    task automatic step();
        bit rdy, acc, prod, hit;
        logic [31:0] tgt, lnk;
        @(negedge clk);
        rdy = !flush && (!m_valid || redir_ready);
        check("req_ready", 32'(req_ready), 32'(rdy));
        acc  = req_valid && rdy;
        prod = acc && !(req_kind == 2'b11 && !req_taken);
        tgt  = model_target(req_kind, req_pc, req_index, req_reg, req_offset);
        lnk  = req_pc + 32'd4;
        hit  = 1'b0;
        if (RAS_ON && acc && req_kind == 2'b01) begin
            ras_m.push_back(lnk);
            if (ras_m.size() > RAS_DEPTH) void'(ras_m.pop_front());
        end
        if (RAS_ON && acc && req_kind == 2'b10 && ras_m.size() > 0) begin
            hit = (ras_m[$] == req_reg);
            void'(ras_m.pop_back());
        end
        if (flush) m_valid = 1'b0;
        else if (prod) begin
            m_valid = 1'b1; m_target = tgt; m_link = lnk;
            m_we = (req_kind == 2'b01); m_hit = hit;
        end else if (redir_ready) m_valid = 1'b0;
        @(posedge clk);
        #1;
        check("redir_valid", 32'(redir_valid), 32'(m_valid));
        if (m_valid) begin
            check("redir_target", redir_target, m_target);
            check("redir_link", redir_link, m_link);
            check("redir_link_we", 32'(redir_link_we), 32'(m_we));
            check("ras_hit", 32'(ras_hit), 32'(m_hit));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(redir_valid), 32'd0);
        check({tag, "_target"}, redir_target, 32'd0);
        check({tag, "_link"}, redir_link, 32'd0);
        check({tag, "_we"}, 32'(redir_link_we), 32'd0);
        check({tag, "_hit"}, 32'(ras_hit), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  k;
        logic [31:0] rg;

        // Reset state.
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAS: five JALs overflow a 4-deep stack, then five JRs unwind it.
        for (int i = 1; i <= 5; i++) begin
            drive(1, 2'b01, 32'(i * 256), 26'(i), 32'd0, 16'd0, 0, 0, 1);
            step();
        end
        for (int i = 5; i >= 1; i--) begin
            drive(1, 2'b10, 32'h8000, 26'd0, 32'(i * 256 + 4), 16'd0, 0, 0, 1);
            step();
            check("ras_seq_hit", 32'(ras_hit), 32'(RAS_ON && i > 1));
        end

        // J with upper PC bits preserved.
        drive(1, 2'b00, 32'hA000_0004, 26'h0000100, 32'd0, 16'd0, 0, 0, 1);
        step();
        check("j_target", redir_target, 32'hA000_0400);
        check("j_we", 32'(redir_link_we), 32'd0);

        // JAL link value.
        drive(1, 2'b01, 32'h0040_0010, 26'h10, 32'd0, 16'd0, 0, 0, 1);
        step();
        check("jal_link", redir_link, 32'h0040_0014);
        check("jal_we", 32'(redir_link_we), 32'd1);

        // Backward taken branch, then not taken.
        drive(1, 2'b11, 32'h0000_1000, 26'd0, 32'd0, 16'hFFFE, 1, 0, 1);
        step();
        check("br_target", redir_target, 32'h0000_0FF8);
        drive(1, 2'b11, 32'h0000_1000, 26'd0, 32'd0, 16'hFFFE, 0, 0, 1);
        step();
        check("br_nt_valid", 32'(redir_valid), 32'd0);
        check("br_nt_ready", 32'(req_ready), 32'd1);

        // Back-pressure: hold three cycles, then replace without a bubble.
        drive(1, 2'b00, 32'hA000_0004, 26'h0000200, 32'd0, 16'd0, 0, 0, 0);
        step();
        drive(1, 2'b10, 32'h0, 26'd0, 32'h1234_5678, 16'd0, 0, 0, 0);
        repeat (3) begin
            step();
            check("bp_hold_target", redir_target, 32'hA000_0800);
        end
        redir_ready = 1'b1;
        step();
        check("bp_replace_target", redir_target, 32'h1234_5678);
        check("bp_replace_valid", 32'(redir_valid), 32'd1);

        // Flush while FULL with a request present.
        drive(1, 2'b01, 32'h0000_0700, 26'd0, 32'd0, 16'd0, 0, 1, 0);
        step();
        check("flush_valid", 32'(redir_valid), 32'd0);
        drive(0, 2'b00, 32'd0, 26'd0, 32'd0, 16'd0, 0, 0, 1);
        step();

        // Randomized traffic against the model.
        repeat (400) begin
            k  = 2'($urandom_range(3));
            rg = $urandom();
            if ($urandom_range(1) == 1 && ras_m.size() > 0) rg = ras_m[$];
            drive($urandom_range(3) != 0, k, $urandom(), 26'($urandom()), rg,
                  16'($urandom()), $urandom_range(1) == 1, $urandom_range(9) == 0,
                  $urandom_range(9) < 7);
            step();
        end

        // Reset mid-FULL clears everything immediately.
        drive(1, 2'b01, 32'h0000_0900, 26'h55, 32'd0, 16'd0, 0, 0, 0);
        step();
        drive(0, 2'b00, 32'd0, 26'd0, 32'd0, 16'd0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        m_valid = 1'b0; m_target = '0; m_link = '0; m_we = 1'b0; m_hit = 1'b0;
        ras_m.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 2'b01, 32'h0000_0A00, 26'h40, 32'd0, 16'd0, 0, 0, 0);
        step();
        check("post_reset_valid", 32'(redir_valid), 32'd1);
        check("post_reset_link", redir_link, 32'h0000_0A04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
